// File: rtl/aes_dpc_multi.sv
// Iterative AES-128/192/256 encrypt/decrypt data path, one round per clock, external same-cycle S-box.
// Latency: accept in cycle T -> o_dout_en pulse in cycle T+Nr (10/12/14).
// Backpressure: o_ready only in IDLE; i_din_en while busy is ignored, unsupported key lengths pulse o_err.
module aes_dpc_multi #(
    parameter int MAX_NR = 14,
    parameter int KW     = 128 * (MAX_NR + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_flag,
    input  logic [1:0]    i_klen,
    input  logic [KW-1:0] i_keyex,
    input  logic [127:0]  i_din,
    input  logic          i_din_en,
    output logic          o_ready,
    output logic          o_busy,
    output logic [127:0]  o_dout,
    output logic          o_dout_en,
    output logic          o_err,
    output logic [127:0]  o_sbox_din,
    input  logic [127:0]  i_sbox_dout
);

    typedef enum logic {S_IDLE, S_ROUND} state_t;

    state_t        r_state, w_state_nxt;
    logic          r_flag, r_dout_en, r_err;
    logic [3:0]    r_nr, r_cnt;
    logic [127:0]  r_data, r_dout;

    logic          w_idle, w_klen_ok, w_accept, w_reject, w_flag, w_last, w_final;
    logic [3:0]    w_nr_in, w_nr, w_rnd;
    logic [127:0]  w_src, w_round;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // GF(2^8) multiply by a small constant (2, 3, 9, 11, 13, 14 used)
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [3:0] m);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // Byte i of the state lives at [127-8*i -: 8], column-major (i = row + 4*col)
    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        int src;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = inv ? (r + 4 * ((c - r + 4) % 4)) : (r + 4 * ((c + r) % 4));
                o[127-8*(r+4*c) -: 8] = s[127-8*src -: 8];
            end
        end
        return o;
    endfunction

    // Circulant column mix: forward {2,3,1,1}, inverse {14,11,13,9}
    function automatic logic [127:0] mix_cols(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        logic [3:0]   m0, m1, m2, m3;
        m0 = inv ? 4'd14 : 4'd2;
        m1 = inv ? 4'd11 : 4'd3;
        m2 = inv ? 4'd13 : 4'd1;
        m3 = inv ? 4'd9  : 4'd1;
        o  = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = gm(s[127-8*(4*c+r)         -: 8], m0)
                                      ^ gm(s[127-8*(4*c+(r+1)%4)   -: 8], m1)
                                      ^ gm(s[127-8*(4*c+(r+2)%4)   -: 8], m2)
                                      ^ gm(s[127-8*(4*c+(r+3)%4)   -: 8], m3);
            end
        end
        return o;
    endfunction

    // Out-of-range indices only occur for requests that are being rejected
    function automatic logic [127:0] rk_sel(input logic [3:0] k);
        int idx;
        idx = (int'(k) > MAX_NR) ? 0 : int'(k);
        return i_keyex[KW-1-128*idx -: 128];
    endfunction

    // Control: mode decode, accept/reject, active round and next state
    always_comb begin
        w_nr_in = 4'd0;
        case (i_klen)
            2'd0:    w_nr_in = 4'd10;
            2'd1:    w_nr_in = 4'd12;
            2'd2:    w_nr_in = 4'd14;
            default: w_nr_in = 4'd0;
        endcase
        w_klen_ok   = (i_klen != 2'd3) && (int'(w_nr_in) <= MAX_NR);
        w_idle      = (r_state == S_IDLE);
        w_accept    = w_idle && i_din_en && w_klen_ok;
        w_reject    = w_idle && i_din_en && !w_klen_ok;
        w_flag      = w_idle ? i_flag  : r_flag;
        w_nr        = w_idle ? w_nr_in : r_nr;
        w_rnd       = w_idle ? 4'd1    : r_cnt + 4'd1;
        w_last      = (w_rnd == w_nr);
        w_final     = !w_idle && w_last;
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_ROUND;
            S_ROUND: if (w_last)   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // S-box feed: round 1 starts from the whitened input, later rounds from the state register
    always_comb begin
        w_src      = w_idle ? (i_din ^ (w_flag ? rk_sel(4'd0) : rk_sel(w_nr))) : r_data;
        o_sbox_din = '0;
        if (w_accept || !w_idle) o_sbox_din = shift_rows(w_src, !w_flag);
    end

    // Round completion from the S-box result
    always_comb begin
        w_round = '0;
        if (w_flag) begin
            if (w_last) w_round = i_sbox_dout ^ rk_sel(w_rnd);
            else        w_round = mix_cols(i_sbox_dout, 1'b0) ^ rk_sel(w_rnd);
        end else begin
            if (w_last) w_round = i_sbox_dout ^ rk_sel(4'd0);
            else        w_round = mix_cols(i_sbox_dout ^ rk_sel(w_nr - w_rnd), 1'b1);
        end
    end

    // State, latched mode, round counter and registered result
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_flag    <= 1'b0;
            r_nr      <= 4'd0;
            r_cnt     <= 4'd0;
            r_data    <= '0;
            r_dout    <= '0;
            r_dout_en <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_dout_en <= w_final;
            r_err     <= w_reject;
            if (w_accept) begin
                r_flag <= i_flag;
                r_nr   <= w_nr_in;
                r_cnt  <= 4'd1;
                r_data <= w_round;
            end else if (!w_idle) begin
                r_cnt  <= r_cnt + 4'd1;
                r_data <= w_round;
                if (w_final) r_dout <= w_round;
            end
        end
    end

    assign o_ready   = (r_state == S_IDLE);
    assign o_busy    = (r_state == S_ROUND);
    assign o_dout    = r_dout;
    assign o_dout_en = r_dout_en;
    assign o_err     = r_err;

endmodule

// File: tb/tb_aes_dpc_multi.sv
// Directed-vector bench for aes_dpc_multi: FIPS-197 vectors, back-to-back, rejects, reset abort.
// Provides the combinational S-box and the key expansion around the core.
// A second instance with MAX_NR=12 exercises rejection of AES-256.
module tb_aes_dpc_multi;

    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_flag;
    logic [1:0]    i_klen;
    logic [1919:0] i_keyex;
    logic [127:0]  i_din;
    logic          i_din_en, i_din_en2;
    logic          sb_dec;

    logic          o_ready, o_busy, o_dout_en, o_err;
    logic [127:0]  o_dout, sb_in, sb_out;
    logic          o_ready2, o_busy2, o_dout_en2, o_err2;
    logic [127:0]  o_dout2, sb_in2, sb_out2;

    logic [7:0]    fsb [256];
    logic [7:0]    isb [256];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    aes_dpc_multi #(.MAX_NR(14)) dut (
        .i_clk(clk), .i_rst(rst), .i_flag(i_flag), .i_klen(i_klen), .i_keyex(i_keyex),
        .i_din(i_din), .i_din_en(i_din_en), .o_ready(o_ready), .o_busy(o_busy),
        .o_dout(o_dout), .o_dout_en(o_dout_en), .o_err(o_err),
        .o_sbox_din(sb_in), .i_sbox_dout(sb_out)
    );

    aes_dpc_multi #(.MAX_NR(12)) dut12 (
        .i_clk(clk), .i_rst(rst), .i_flag(i_flag), .i_klen(i_klen), .i_keyex(i_keyex[1919 -: 1664]),
        .i_din(i_din), .i_din_en(i_din_en2), .o_ready(o_ready2), .o_busy(o_busy2),
        .o_dout(o_dout2), .o_dout_en(o_dout_en2), .o_err(o_err2),
        .o_sbox_din(sb_in2), .i_sbox_dout(sb_out2)
    );

    // External combinational S-box for each instance
    always_comb begin
        sb_out = '0;
        for (int i = 0; i < 16; i++)
            sb_out[127-8*i -: 8] = sb_dec ? isb[sb_in[127-8*i -: 8]] : fsb[sb_in[127-8*i -: 8]];
    end

    always_comb begin
        sb_out2 = '0;
        for (int i = 0; i < 16; i++)
            sb_out2[127-8*i -: 8] = sb_dec ? isb[sb_in2[127-8*i -: 8]] : fsb[sb_in2[127-8*i -: 8]];
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [7:0] tgm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {fsb[t[31:24]], fsb[t[23:16]], fsb[t[15:8]], fsb[t[7:0]]};
    endfunction

    // FIPS-197 key expansion for key bytes 00,01,..; rk[k] packed from the MSB end
    function automatic logic [1919:0] key_exp(input int nk);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1919:0] ke;
        int            nr;
        nr = nk + 6;
        rc = 8'h01;
        ke = '0;
        for (int i = 0; i < nk; i++)
            w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int k = 0; k <= nr; k++)
            ke[1919-128*k -: 128] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
        return ke;
    endfunction

    // One block on the main instance; starts and ends one cycle after an edge
    task automatic run_block(input logic flag, input logic [1:0] klen, input logic [127:0] din,
                             input logic [127:0] exp, input string tag);
        int nk, nr, lat;
        bit found;
        nk = (klen == 2'd0) ? 4 : (klen == 2'd1) ? 6 : 8;
        nr = nk + 6;
        chk({tag, " ready"}, o_ready, 1);
        i_flag = flag; i_klen = klen; i_keyex = key_exp(nk); i_din = din; i_din_en = 1'b1;
        sb_dec = !flag;
        @(posedge clk); #1;
        i_din_en = 1'b0; i_din = {4{$urandom}}; i_klen = 2'd3; i_flag = !flag;
        chk({tag, " busy"}, {o_busy, o_ready}, 2'b10);
        lat = 1; found = 0;
        while (lat <= 20 && !found) begin
            if (o_dout_en) found = 1;
            else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        chk({tag, " latency"}, lat, nr);
        chk({tag, " dout"}, o_dout, exp);
        @(posedge clk); #1;
        chk({tag, " pulse"}, o_dout_en, 0);
        chk({tag, " hold"}, o_dout, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0] v;
        logic [127:0] q [$];
        int n_acc, n_out, n_err, cyc, n_en;
        logic [1:0] kl;

        for (int x = 0; x < 256; x++) begin
            v = 8'h00;
            for (int y = 1; y < 256; y++)
                if (tgm(8'(x), 8'(y)) == 8'h01) v = 8'(y);
            fsb[x] = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) isb[fsb[x]] = 8'(x);

        rst = 1'b1; i_flag = 1'b0; i_klen = 2'd0; i_keyex = '0; i_din = '0;
        i_din_en = 1'b0; i_din_en2 = 1'b0; sb_dec = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst ready", o_ready, 1);
        chk("rst busy", o_busy, 0);
        chk("rst dout", o_dout, 0);
        chk("rst dout_en", o_dout_en, 0);
        chk("rst err", o_err, 0);
        chk("rst sbox_din idle", sb_in, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_block(1'b1, 2'd0, PT, C128, "enc128");
        run_block(1'b1, 2'd1, PT, C192, "enc192");
        run_block(1'b1, 2'd2, PT, C256, "enc256");
        run_block(1'b0, 2'd0, C128, PT, "dec128");
        run_block(1'b0, 2'd1, C192, PT, "dec192");
        run_block(1'b0, 2'd2, C256, PT, "dec256");

        // Invalid key length on the full instance
        i_klen = 2'd3; i_din = C256; i_din_en = 1'b1;
        @(posedge clk); #1;
        i_din_en = 1'b0;
        chk("klen3 err", o_err, 1);
        chk("klen3 ready", o_ready, 1);
        chk("klen3 dout", o_dout, PT);
        chk("klen3 dout_en", o_dout_en, 0);
        @(posedge clk); #1;
        chk("klen3 err pulse", o_err, 0);

        // AES-256 on the 12-round instance is rejected, AES-192 accepted
        i_klen = 2'd2; i_flag = 1'b1; i_din_en2 = 1'b1;
        @(posedge clk); #1;
        i_din_en2 = 1'b0;
        chk("nr12 err", o_err2, 1);
        chk("nr12 ready", {o_ready2, o_busy2}, 2'b10);
        chk("nr12 dout", o_dout2, 0);
        chk("nr12 main quiet", o_err, 0);
        @(posedge clk); #1;
        chk("nr12 err pulse", o_err2, 0);
        i_klen = 2'd1; i_din_en2 = 1'b1;
        @(posedge clk); #1;
        i_din_en2 = 1'b0;
        chk("nr12 k192 accept", {o_busy2, o_err2}, 2'b10);

        // Back-to-back with i_din_en held high, alternating AES-128 / AES-256
        n_acc = 0; n_out = 0; n_err = 0; cyc = 0;
        sb_dec = 1'b0; i_flag = 1'b1; i_din = PT; i_din_en = 1'b1;
        while (cyc < 200 && !(n_acc == 4 && q.size() == 0)) begin
            if (o_err) n_err++;
            if (o_dout_en) begin
                n_out++;
                if (q.size() > 0) chk("b2b dout", o_dout, q.pop_front());
                else chk("b2b extra dout_en", 1, 0);
            end
            if (o_ready) begin
                if (n_acc < 4) begin
                    kl = (n_acc % 2 == 0) ? 2'd0 : 2'd2;
                    i_klen = kl;
                    i_keyex = key_exp(kl == 2'd0 ? 4 : 8);
                    q.push_back(kl == 2'd0 ? C128 : C256);
                    n_acc++;
                end else begin
                    i_din_en = 1'b0;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        i_din_en = 1'b0;
        chk("b2b timeout", cyc < 200, 1);
        chk("b2b count", n_out, 4);
        chk("b2b no err", n_err, 0);

        // Reset in cycle T+5 of an AES-256 block aborts it
        i_flag = 1'b1; i_klen = 2'd2; i_keyex = key_exp(8); i_din = PT; i_din_en = 1'b1;
        @(posedge clk); #1;
        i_din_en = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort ready", {o_ready, o_busy}, 2'b10);
        chk("abort dout", o_dout, 0);
        n_en = 0;
        repeat (20) begin
            if (o_dout_en) n_en++;
            @(posedge clk); #1;
        end
        chk("abort no dout_en", n_en, 0);

        run_block(1'b1, 2'd0, PT, C128, "post-rst enc128");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
